// File: rtl/mesh_node_interface.sv
// Node-side endpoint of one mesh port: TX FIFO injecting words into the network under hold,
// RX FIFO absorbing network writes with early hold-back and a host valid/ready interface.
module mesh_node_interface #(
   parameter int unsigned FIFO_WIDTH = 632,
   parameter int unsigned TX_DEPTH   = 4,
   parameter int unsigned RX_DEPTH   = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [FIFO_WIDTH-1:0] txData,
   input  logic                  txValid,
   output logic                  txReady,
   output logic [FIFO_WIDTH-1:0] nodeToNetworkData,
   output logic                  nodeToNetworkWriteRequest,
   input  logic                  networkToNodeHoldRequest,
   input  logic [FIFO_WIDTH-1:0] networkToNodeData,
   input  logic                  networkToNodeWriteRequest,
   output logic                  nodeToNetworkHoldRequest,
   output logic [FIFO_WIDTH-1:0] rxData,
   output logic                  rxValid,
   input  logic                  rxReady,
   output logic [15:0]           txPacketCount,
   output logic [15:0]           rxPacketCount,
   output logic                  rxOverflow
);

   localparam int unsigned TxAw      = $clog2(TX_DEPTH);
   localparam int unsigned RxAw      = $clog2(RX_DEPTH);
   localparam int unsigned RxHoldInt = RX_DEPTH - 1;
   localparam logic [TxAw:0] TxFull  = TX_DEPTH[TxAw:0];
   localparam logic [RxAw:0] RxFull  = RX_DEPTH[RxAw:0];
   localparam logic [RxAw:0] RxHold  = RxHoldInt[RxAw:0];

   // ---------------- TX path ----------------
   logic [FIFO_WIDTH-1:0] tx_mem [TX_DEPTH];
   logic [TxAw-1:0]       tx_wr_ptr, tx_rd_ptr;
   logic [TxAw:0]         tx_cnt;
   logic                  tx_push, tx_pop, tx_empty;

   assign tx_empty                  = (tx_cnt == '0);
   assign txReady                   = (tx_cnt < TxFull);
   assign nodeToNetworkWriteRequest = !tx_empty && !networkToNodeHoldRequest;
   assign nodeToNetworkData         = tx_empty ? '0 : tx_mem[tx_rd_ptr];
   assign tx_push                   = txValid && txReady;
   assign tx_pop                    = nodeToNetworkWriteRequest;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tx_wr_ptr     <= '0;
         tx_rd_ptr     <= '0;
         tx_cnt        <= '0;
         txPacketCount <= '0;
      end else begin
         if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
         if (tx_pop) begin
            tx_rd_ptr     <= tx_rd_ptr + 1'b1;
            txPacketCount <= txPacketCount + 16'd1;
         end
         if (tx_push && !tx_pop)      tx_cnt <= tx_cnt + 1'b1;
         else if (!tx_push && tx_pop) tx_cnt <= tx_cnt - 1'b1;
      end
   end

   // Storage needs no reset: reads are gated by the registered count.
   always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wr_ptr] <= txData;
   end

   // ---------------- RX path ----------------
   logic [FIFO_WIDTH-1:0] rx_mem [RX_DEPTH];
   logic [RxAw-1:0]       rx_wr_ptr, rx_rd_ptr;
   logic [RxAw:0]         rx_cnt;
   logic                  rx_accept, rx_pop, rx_empty;

   assign rx_empty                 = (rx_cnt == '0);
   assign rxValid                  = !rx_empty;
   assign rxData                   = rx_empty ? '0 : rx_mem[rx_rd_ptr];
   assign rx_pop                   = rxValid && rxReady;
   // A write into a full FIFO still lands if the host frees the head slot this cycle.
   assign rx_accept                = networkToNodeWriteRequest && ((rx_cnt < RxFull) || rx_pop);
   // Hold one entry early so a write already in flight has somewhere to go.
   assign nodeToNetworkHoldRequest = (rx_cnt >= RxHold);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_wr_ptr     <= '0;
         rx_rd_ptr     <= '0;
         rx_cnt        <= '0;
         rxPacketCount <= '0;
         rxOverflow    <= 1'b0;
      end else begin
         if (rx_accept) begin
            rx_wr_ptr     <= rx_wr_ptr + 1'b1;
            rxPacketCount <= rxPacketCount + 16'd1;
         end
         if (rx_pop) rx_rd_ptr <= rx_rd_ptr + 1'b1;
         if (networkToNodeWriteRequest && !rx_accept) rxOverflow <= 1'b1;
         if (rx_accept && !rx_pop)      rx_cnt <= rx_cnt + 1'b1;
         else if (!rx_accept && rx_pop) rx_cnt <= rx_cnt - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rx_accept) rx_mem[rx_wr_ptr] <= networkToNodeData;
   end

endmodule

// File: tb/tb_mesh_node_interface.sv
// Scoreboard bench for mesh_node_interface: inputs change 1 time unit after the rising edge,
// outputs are compared on the falling edge against queues filled as stimulus is accepted.
module tb_mesh_node_interface;
   localparam int W = 632;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [W-1:0] txData = '0;
   logic         txValid = 1'b0;
   logic         txReady;
   logic [W-1:0] nodeToNetworkData;
   logic         nodeToNetworkWriteRequest;
   logic         hold = 1'b0;
   logic [W-1:0] netData = '0;
   logic         netWr = 1'b0;
   logic         nodeToNetworkHoldRequest;
   logic [W-1:0] rxData;
   logic         rxValid;
   logic         rxReady = 1'b0;
   logic [15:0]  txPacketCount, rxPacketCount;
   logic         rxOverflow;

   int           tests = 0;
   int           fails = 0;
   logic [W-1:0] tx_q[$];
   logic [W-1:0] rx_q[$];
   logic [15:0]  tx_pkt_m = '0;
   logic [15:0]  rx_pkt_m = '0;
   logic         ovf_m = 1'b0;

   mesh_node_interface #(.FIFO_WIDTH(W), .TX_DEPTH(4), .RX_DEPTH(4)) dut (
      .clk                       (clk),
      .reset                     (reset),
      .txData                    (txData),
      .txValid                   (txValid),
      .txReady                   (txReady),
      .nodeToNetworkData         (nodeToNetworkData),
      .nodeToNetworkWriteRequest (nodeToNetworkWriteRequest),
      .networkToNodeHoldRequest  (hold),
      .networkToNodeData         (netData),
      .networkToNodeWriteRequest (netWr),
      .nodeToNetworkHoldRequest  (nodeToNetworkHoldRequest),
      .rxData                    (rxData),
      .rxValid                   (rxValid),
      .rxReady                   (rxReady),
      .txPacketCount             (txPacketCount),
      .rxPacketCount             (rxPacketCount),
      .rxOverflow                (rxOverflow)
   );

   always #5 clk = ~clk;

   task automatic test_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      tests++; if (txReady !== 1'b1) begin fails++; $display("FAIL reset_txReady: got %0b want 1", txReady); end
      tests++; if (nodeToNetworkWriteRequest !== 1'b0) begin fails++; $display("FAIL reset_wreq: got %0b want 0", nodeToNetworkWriteRequest); end
      tests++; if (nodeToNetworkData !== '0) begin fails++; $display("FAIL reset_txdata: got %0h want 0", nodeToNetworkData); end
      tests++; if (nodeToNetworkHoldRequest !== 1'b0) begin fails++; $display("FAIL reset_hold: got %0b want 0", nodeToNetworkHoldRequest); end
      tests++; if (rxValid !== 1'b0) begin fails++; $display("FAIL reset_rxValid: got %0b want 0", rxValid); end
      tests++; if (rxData !== '0) begin fails++; $display("FAIL reset_rxData: got %0h want 0", rxData); end
      tests++; if (txPacketCount !== 16'd0) begin fails++; $display("FAIL reset_txcnt: got %0d want 0", txPacketCount); end
      tests++; if (rxPacketCount !== 16'd0) begin fails++; $display("FAIL reset_rxcnt: got %0d want 0", rxPacketCount); end
      tests++; if (rxOverflow !== 1'b0) begin fails++; $display("FAIL reset_ovf: got %0b want 0", rxOverflow); end
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic test_tx_basic();
      int           sz;
      logic [W-1:0] exp;
      hold = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk); #1;
         txValid = (k < 3);
         txData  = W'(k + 1);
         @(negedge clk);
         sz  = tx_q.size();
         exp = (sz != 0) ? tx_q[0] : '0;
         tests++; if (nodeToNetworkWriteRequest !== (sz != 0)) begin fails++; $display("FAIL tx_basic_wreq: cycle %0d got %0b want %0b", k, nodeToNetworkWriteRequest, sz != 0); end
         tests++; if (nodeToNetworkData !== exp) begin fails++; $display("FAIL tx_basic_data: cycle %0d got %0h want %0h", k, nodeToNetworkData, exp); end
         tests++; if (txReady !== (sz < 4)) begin fails++; $display("FAIL tx_basic_ready: cycle %0d got %0b want %0b", k, txReady, sz < 4); end
         if (sz != 0) begin void'(tx_q.pop_front()); tx_pkt_m++; end
         if (txValid && sz < 4) tx_q.push_back(txData);
      end
      tests++; if (txPacketCount !== 16'd3) begin fails++; $display("FAIL tx_basic_count: got %0d want 3", txPacketCount); end
   endtask

   task automatic test_tx_backpressure();
      int           sz;
      int           pushed = 0;
      logic [W-1:0] exp;
      hold = 1'b1;
      for (int k = 0; k < 14; k++) begin
         @(posedge clk); #1;
         if (k == 6) begin hold = 1'b0; txValid = 1'b0; end
         else if (k < 6) begin txValid = 1'b1; txData = W'(32'h10 + pushed); end
         @(negedge clk);
         sz  = tx_q.size();
         exp = (sz != 0) ? tx_q[0] : '0;
         tests++; if (nodeToNetworkWriteRequest !== (sz != 0 && !hold)) begin fails++; $display("FAIL tx_bp_wreq: cycle %0d got %0b want %0b", k, nodeToNetworkWriteRequest, sz != 0 && !hold); end
         tests++; if (nodeToNetworkData !== exp) begin fails++; $display("FAIL tx_bp_data: cycle %0d got %0h want %0h", k, nodeToNetworkData, exp); end
         tests++; if (txReady !== (sz < 4)) begin fails++; $display("FAIL tx_bp_ready: cycle %0d got %0b want %0b", k, txReady, sz < 4); end
         if (sz != 0 && !hold) begin void'(tx_q.pop_front()); tx_pkt_m++; end
         if (txValid && sz < 4) begin tx_q.push_back(txData); pushed++; end
      end
      tests++; if (pushed != 4) begin fails++; $display("FAIL tx_bp_pushed: got %0d want 4", pushed); end
      tests++; if (txReady !== 1'b1) begin fails++; $display("FAIL tx_bp_ready_end: got %0b want 1", txReady); end
      tests++; if (txPacketCount !== tx_pkt_m) begin fails++; $display("FAIL tx_bp_count: got %0d want %0d", txPacketCount, tx_pkt_m); end
   endtask

   task automatic test_rx_hold_overflow();
      bit [10:0]    wr_s  = 11'b000_0001_1111;
      bit [10:0]    rdy_s = 11'b111_1110_0000;
      int           d_s[5] = '{'hA, 'hB, 'hC, 'hD, 'hE};
      int           sz;
      logic         pop_m;
      logic [W-1:0] exp;
      for (int k = 0; k < 11; k++) begin
         @(posedge clk); #1;
         netWr   = wr_s[k];
         netData = (k < 5) ? W'(d_s[k]) : '0;
         rxReady = rdy_s[k];
         @(negedge clk);
         sz    = rx_q.size();
         pop_m = (sz != 0) && rxReady;
         exp   = (sz != 0) ? rx_q[0] : '0;
         tests++; if (nodeToNetworkHoldRequest !== (sz >= 3)) begin fails++; $display("FAIL rx_ho_hold: cycle %0d got %0b want %0b", k, nodeToNetworkHoldRequest, sz >= 3); end
         tests++; if (rxValid !== (sz != 0)) begin fails++; $display("FAIL rx_ho_valid: cycle %0d got %0b want %0b", k, rxValid, sz != 0); end
         tests++; if (rxData !== exp) begin fails++; $display("FAIL rx_ho_data: cycle %0d got %0h want %0h", k, rxData, exp); end
         tests++; if (rxOverflow !== ovf_m) begin fails++; $display("FAIL rx_ho_ovf: cycle %0d got %0b want %0b", k, rxOverflow, ovf_m); end
         tests++; if (rxPacketCount !== rx_pkt_m) begin fails++; $display("FAIL rx_ho_count: cycle %0d got %0d want %0d", k, rxPacketCount, rx_pkt_m); end
         if (pop_m) void'(rx_q.pop_front());
         if (netWr) begin
            if (sz < 4 || pop_m) begin rx_q.push_back(netData); rx_pkt_m++; end
            else ovf_m = 1'b1;
         end
      end
      tests++; if (rxOverflow !== 1'b1) begin fails++; $display("FAIL rx_ho_ovf_end: got %0b want 1", rxOverflow); end
      tests++; if (rxPacketCount !== 16'd4) begin fails++; $display("FAIL rx_ho_count_end: got %0d want 4", rxPacketCount); end
   endtask

   task automatic test_reset_midstream();
      hold    = 1'b1;
      rxReady = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         txValid = 1'b1;
         txData  = W'(32'h31 + k);
         netWr   = (k < 2);
         netData = W'(32'h41 + k);
      end
      @(posedge clk); #1;
      txValid = 1'b0;
      netWr   = 1'b0;
      @(negedge clk);
      tests++; if (rxValid !== 1'b1) begin fails++; $display("FAIL mid_pre_rxValid: got %0b want 1", rxValid); end
      tests++; if (nodeToNetworkData !== W'(32'h31)) begin fails++; $display("FAIL mid_pre_txdata: got %0h want 31", nodeToNetworkData); end
      #2;
      reset = 1'b1;
      hold  = 1'b0;
      #1;
      tests++; if (txReady !== 1'b1) begin fails++; $display("FAIL mid_txReady: got %0b want 1", txReady); end
      tests++; if (nodeToNetworkWriteRequest !== 1'b0) begin fails++; $display("FAIL mid_wreq: got %0b want 0", nodeToNetworkWriteRequest); end
      tests++; if (nodeToNetworkData !== '0) begin fails++; $display("FAIL mid_txdata: got %0h want 0", nodeToNetworkData); end
      tests++; if (rxValid !== 1'b0) begin fails++; $display("FAIL mid_rxValid: got %0b want 0", rxValid); end
      tests++; if (rxData !== '0) begin fails++; $display("FAIL mid_rxData: got %0h want 0", rxData); end
      tests++; if (txPacketCount !== 16'd0) begin fails++; $display("FAIL mid_txcnt: got %0d want 0", txPacketCount); end
      tests++; if (rxPacketCount !== 16'd0) begin fails++; $display("FAIL mid_rxcnt: got %0d want 0", rxPacketCount); end
      tests++; if (rxOverflow !== 1'b0) begin fails++; $display("FAIL mid_ovf: got %0b want 0", rxOverflow); end
      @(posedge clk); #1;
      reset = 1'b0;
      tx_q.delete();
      rx_q.delete();
      tx_pkt_m = '0;
      rx_pkt_m = '0;
      ovf_m    = 1'b0;
   endtask

   task automatic test_rx_full_pop_wrap();
      bit [6:0]     wr_s  = 7'b001_1111;
      bit [6:0]     rdy_s = 7'b001_0000;
      int           d_s[5] = '{'h20, 'h21, 'h22, 'h23, 'hF};
      int           sz;
      logic         pop_m;
      logic [W-1:0] exp;
      for (int k = 0; k < 7; k++) begin
         @(posedge clk); #1;
         netWr   = wr_s[k];
         netData = (k < 5) ? W'(d_s[k]) : '0;
         rxReady = rdy_s[k];
         @(negedge clk);
         sz    = rx_q.size();
         pop_m = (sz != 0) && rxReady;
         exp   = (sz != 0) ? rx_q[0] : '0;
         tests++; if (rxData !== exp) begin fails++; $display("FAIL rx_fp_data: cycle %0d got %0h want %0h", k, rxData, exp); end
         tests++; if (rxOverflow !== ovf_m) begin fails++; $display("FAIL rx_fp_ovf: cycle %0d got %0b want %0b", k, rxOverflow, ovf_m); end
         tests++; if (rxPacketCount !== rx_pkt_m) begin fails++; $display("FAIL rx_fp_count: cycle %0d got %0d want %0d", k, rxPacketCount, rx_pkt_m); end
         if (pop_m) void'(rx_q.pop_front());
         if (netWr) begin
            if (sz < 4 || pop_m) begin rx_q.push_back(netData); rx_pkt_m++; end
            else ovf_m = 1'b1;
         end
      end
      tests++; if (rxPacketCount !== 16'd5) begin fails++; $display("FAIL rx_fp_count_end: got %0d want 5", rxPacketCount); end
      // Stream full-rate write+pop until the counter sits at 65535, then one more accept.
      @(posedge clk); #1;
      netWr   = 1'b1;
      rxReady = 1'b1;
      repeat (65530) @(posedge clk);
      #1;
      netWr = 1'b0;
      @(negedge clk);
      tests++; if (rxPacketCount !== 16'hFFFF) begin fails++; $display("FAIL rx_wrap_max: got %0d want 65535", rxPacketCount); end
      @(posedge clk); #1;
      netWr = 1'b1;
      @(posedge clk); #1;
      netWr = 1'b0;
      @(negedge clk);
      tests++; if (rxPacketCount !== 16'd0) begin fails++; $display("FAIL rx_wrap_zero: got %0d want 0", rxPacketCount); end
      tests++; if (rxOverflow !== 1'b0) begin fails++; $display("FAIL rx_wrap_ovf: got %0b want 0", rxOverflow); end
   endtask

   initial begin
      test_reset();
      test_tx_basic();
      test_tx_backpressure();
      test_rx_hold_overflow();
      test_reset_midstream();
      test_rx_full_pop_wrap();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mesh_node_interface.md
Name: mesh_node_interface

Overview:
- Node-side endpoint of one mesh port, sitting between a traffic source/sink and the network's per-node data/writeRequest/holdRequest triple.
- Transmit path: buffers host words in a TX FIFO and injects them into the network, obeying the network's hold.
- Receive path: accepts network writes into an RX FIFO, asserts hold back to the network before overflow, and presents words to the host on a valid/ready interface.

Parameters:
- FIFO_WIDTH, 632, width of one data word (matches network data width).
- TX_DEPTH, 4, TX FIFO entries; power of 2, >=2.
- RX_DEPTH, 4, RX FIFO entries; power of 2, >=2.

Ports:
- clk  input  1  clock; all state on rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- txData  input  FIFO_WIDTH  host word to send.
- txValid  input  1  host offers txData.
- txReady  output  1  TX FIFO can accept.
- nodeToNetworkData  output  FIFO_WIDTH  word into network.
- nodeToNetworkWriteRequest  output  1  nodeToNetworkData valid and transferred this cycle.
- networkToNodeHoldRequest  input  1  network cannot accept; no write allowed.
- networkToNodeData  input  FIFO_WIDTH  word from network.
- networkToNodeWriteRequest  input  1  network delivers networkToNodeData this cycle.
- nodeToNetworkHoldRequest  output  1  node requests network to stop writing.
- rxData  output  FIFO_WIDTH  head of RX FIFO to host.
- rxValid  output  1  rxData valid.
- rxReady  input  1  host consumes rxData.
- txPacketCount  output  16  words injected into network, wraps 65535->0.
- rxPacketCount  output  16  words accepted from network, wraps 65535->0.
- rxOverflow  output  1  sticky: a network write was dropped.

Behaviour:
- Reset (async assert, sync release): both FIFOs empty, counters 0, rxOverflow 0.
- Reset outputs: txReady=1, nodeToNetworkWriteRequest=0, nodeToNetworkData=0, nodeToNetworkHoldRequest=0, rxValid=0, rxData=0.
- Reset mid-operation discards all buffered words immediately; no partial transfer completes.

TX path:
- Push when txValid & txReady.
- txReady = (txCount < TX_DEPTH), combinational from registered count.
- nodeToNetworkWriteRequest = !txEmpty & !networkToNodeHoldRequest, combinational.
- nodeToNetworkData = TX head when non-empty, else 0.
- Pop and txPacketCount++ on every cycle nodeToNetworkWriteRequest=1.
- No bypass: a word pushed in cycle N is first offered in cycle N+1.
- Push and pop in the same cycle: count unchanged, order preserved.
- Hold high: head word holds stable; nodeToNetworkWriteRequest=0.

RX path:
- Accept when networkToNodeWriteRequest & ((rxCount < RX_DEPTH) | hostPop).
- hostPop = rxValid & rxReady.
- Accepted word: written at tail, rxPacketCount++.
- Write arriving when full with no simultaneous pop: word dropped, rxOverflow set to 1 until reset, counters unchanged.
- nodeToNetworkHoldRequest = (rxCount >= RX_DEPTH-1), combinational from registered count. The one spare slot absorbs a write already in flight when the network reacts one cycle late.
- rxValid = !rxEmpty; rxData = RX head when non-empty, else 0.
- A word accepted in cycle N is visible on rxValid in cycle N+1.
- Pointers: log2(DEPTH) bits, wrap naturally.
- Counts: log2(DEPTH)+1 bits.
- Counter arithmetic: modulo 2^16.

Test Plan:
- Reset mid-stream: 3 words in TX, 2 in RX, pulse reset -> all outputs reach reset values asynchronously; txReady=1, counters 0.
- TX basic: push 0x1,0x2,0x3 back-to-back with hold=0 -> writeRequest high cycles 1-3 with data 0x1,0x2,0x3; txPacketCount=3.
- TX backpressure: hold=1, push 5 words -> txReady low after 4th push; writeRequest stays 0. Release hold -> 4 words emitted in order, then txReady=1.
- RX hold threshold: rxReady=0, network writes 0xA,0xB,0xC -> hold asserts the cycle after 3rd accept (count 3). A 4th write (0xD) is accepted, rxOverflow=0.
- RX overflow: after 4 stored, 5th write 0xE with rxReady=0 -> dropped, rxOverflow=1, rxPacketCount=4. Then drain with rxReady=1 -> 0xA,0xB,0xC,0xD; hold deasserts when count drops to 2.
- Simultaneous full write+pop and counter wrap: RX full, write 0xF with rxReady=1 -> 0xF accepted, no overflow. Preload rxPacketCount to 65535 and accept 1 word -> counter reads 0.
